// File: rtl/clause_dispatch_fifo_pkg.sv
// rtl/clause_dispatch_fifo_pkg.sv - shared SAT types and sizing for the clause dispatch FIFO
// Contents: NUM_ENGINE (clause lanes per cycle), NUM_CLAUSE (clause entries),
// lit_t (one literal), cla_t (one clause as a pair of literals).
package clause_dispatch_fifo_pkg;

    localparam int NUM_ENGINE = 4;
    localparam int NUM_CLAUSE = 8;

    typedef logic [7:0] lit_t;

    typedef struct packed {
        lit_t lit_a;
        lit_t lit_b;
    } cla_t;

endpackage

// File: rtl/cdf_ptr_ctrl.sv
// rtl/cdf_ptr_ctrl.sv - head/tail/count bookkeeping for the clause dispatch FIFO
// Ports: clock/reset_n; start_in, load_fire_in, recycle_en_in, flush_in, clause_taken_in (requests);
// head_idx_out/tail_idx_out (array indices), count_out, full_out, empty_out, start_q_out,
// avail_out, eff_taken_out, err_out (status for the top-level array and lanes).
module cdf_ptr_ctrl
    import clause_dispatch_fifo_pkg::*;
#(
    parameter int NUM_ENG = NUM_ENGINE,
    parameter int DEPTH   = NUM_CLAUSE,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1,
    localparam int EW     = $clog2(NUM_ENG) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start_in,
    input  logic          load_fire_in,
    input  logic          recycle_en_in,
    input  logic          flush_in,
    input  logic [EW-1:0] clause_taken_in,
    output logic [AW-1:0] head_idx_out,
    output logic [AW-1:0] tail_idx_out,
    output logic [PW-1:0] count_out,
    output logic          full_out,
    output logic          empty_out,
    output logic          start_q_out,
    output logic [EW-1:0] avail_out,
    output logic [EW-1:0] eff_taken_out,
    output logic          err_out
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          start_q, start_d;
    logic          err_q, err_d;
    logic [PW-1:0] count;
    logic [EW-1:0] avail;
    logic [EW-1:0] eff_taken;

    // Pointers carry one extra wrap bit, so the difference is the occupancy
    // even after either pointer has wrapped.
    assign count = tail_q - head_q;

    always_comb begin
        avail = '0;
        if (start_q) begin
            if (count >= PW'(NUM_ENG)) avail = EW'(NUM_ENG);
            else                       avail = EW'(count);
        end
        // With no open round avail is 0, so the take collapses to 0 here too.
        eff_taken = (clause_taken_in > avail) ? avail : clause_taken_in;

        start_d = start_in;
        err_d   = err_q | (start_q && (clause_taken_in > avail));

        if (flush_in) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PW'(eff_taken);
            // Recycled clauses are rewritten at tail, so tail follows head.
            tail_d = tail_q + PW'(load_fire_in) + (recycle_en_in ? PW'(eff_taken) : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign head_idx_out  = head_q[AW-1:0];
    assign tail_idx_out  = tail_q[AW-1:0];
    assign count_out     = count;
    assign full_out      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign empty_out     = start_q && (head_q == tail_q);
    assign start_q_out   = start_q;
    assign avail_out     = avail;
    assign eff_taken_out = eff_taken;
    assign err_out       = err_q;

endmodule

// File: rtl/clause_dispatch_fifo.sv
// rtl/clause_dispatch_fifo.sv - circular clause buffer presenting NUM_ENG head clauses per cycle
// Ports: clock/reset_n; load_valid_in/load_ready_out/clause_in (enqueue); recycle_en_in, flush_in,
// start_in (mode/round control); chosen_uc_in/_valid_in and chosen_uc_out/_valid_out (round literal);
// clause_out/clause_avail_out/clause_taken_in (dispatch lanes); count_out, empty_out, full_out, err_out.
module clause_dispatch_fifo
    import clause_dispatch_fifo_pkg::*;
#(
    parameter int NUM_ENG = NUM_ENGINE,
    parameter int DEPTH   = NUM_CLAUSE,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1,
    localparam int EW     = $clog2(NUM_ENG) + 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load_valid_in,
    output logic                load_ready_out,
    input  cla_t                clause_in,
    input  logic                recycle_en_in,
    input  logic                flush_in,
    input  logic                start_in,
    input  lit_t                chosen_uc_in,
    input  logic                chosen_uc_valid_in,
    output cla_t [NUM_ENG-1:0]  clause_out,
    output logic [EW-1:0]       clause_avail_out,
    input  logic [EW-1:0]       clause_taken_in,
    output lit_t                chosen_uc_out,
    output logic                chosen_uc_valid_out,
    output logic [PW-1:0]       count_out,
    output logic                empty_out,
    output logic                full_out,
    output logic                err_out
);

    logic [AW-1:0] head_idx, tail_idx;
    logic          full, start_q, load_fire;
    logic [EW-1:0] avail, eff_taken;
    lit_t          uc_q, uc_d;
    cla_t          mem_q [DEPTH];
    cla_t          mem_d [DEPTH];
    logic [AW-1:0] ridx, widx;

    assign load_ready_out = !full && !recycle_en_in && !flush_in;
    assign load_fire      = load_valid_in && load_ready_out;

    cdf_ptr_ctrl #(.NUM_ENG(NUM_ENG), .DEPTH(DEPTH)) u_ptr (
        .clock           (clock),
        .reset_n         (reset_n),
        .start_in        (start_in),
        .load_fire_in    (load_fire),
        .recycle_en_in   (recycle_en_in),
        .flush_in        (flush_in),
        .clause_taken_in (clause_taken_in),
        .head_idx_out    (head_idx),
        .tail_idx_out    (tail_idx),
        .count_out       (count_out),
        .full_out        (full),
        .empty_out       (empty_out),
        .start_q_out     (start_q),
        .avail_out       (avail),
        .eff_taken_out   (eff_taken),
        .err_out         (err_out)
    );

    // Lane i shows the i-th clause from head; unused lanes are forced to 0.
    always_comb begin
        ridx = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            ridx          = head_idx + AW'(i);
            clause_out[i] = (EW'(i) < avail) ? mem_q[ridx] : '0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        widx  = '0;
        if (!flush_in) begin
            // Loads and recycling are exclusive because load_ready drops in recycle mode.
            if (load_fire) mem_d[tail_idx] = clause_in;
            if (recycle_en_in) begin
                for (int i = 0; i < NUM_ENG; i++) begin
                    widx = tail_idx + AW'(i);
                    if (EW'(i) < eff_taken) mem_d[widx] = clause_out[i];
                end
            end
        end
        uc_d = chosen_uc_valid_in ? chosen_uc_in : uc_q;
    end

    // Array contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) uc_q <= '0;
        else          uc_q <= uc_d;
    end

    assign clause_avail_out    = avail;
    assign chosen_uc_out       = start_q ? uc_q : '0;
    assign chosen_uc_valid_out = start_q;
    assign full_out            = full;

endmodule
